// File: rtl/tros_meas_sequencer_if.sv
// Control/status bundle between the measurement host logic and the sequencer.
interface tros_meas_sequencer_if #(
    parameter int unsigned GATE_WIDTH = 16
) ();
    logic                  start;
    logic                  abort;
    logic                  continuous;
    logic [GATE_WIDTH-1:0] gate_cycles;
    logic [2:0]            ros_mask;

    logic                  ctr_reset;
    logic                  latch_counter;
    logic                  send_counter;
    logic [1:0]            counter_select;
    logic                  frame_active;
    logic                  busy;
    logic                  done;

    // Host side: issues requests, observes the sequencer.
    modport master (
        output start, abort, continuous, gate_cycles, ros_mask,
        input  ctr_reset, latch_counter, send_counter, counter_select,
               frame_active, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, abort, continuous, gate_cycles, ros_mask,
        output ctr_reset, latch_counter, send_counter, counter_select,
               frame_active, busy, done
    );
endinterface

// File: rtl/tros_meas_sequencer.sv
// Autonomous clear / gate / latch / readout sequencer for the ring-oscillator array.
module tros_meas_sequencer #(
    parameter int unsigned GATE_WIDTH    = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned LOAD_CYCLES   = 4,
    parameter int unsigned FRAME_BITS    = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    tros_meas_sequencer_if.slave  ctl
);

    localparam int unsigned SHIFT_CYCLES = FRAME_BITS + 3;
    localparam int unsigned SL_MAX = (SETTLE_CYCLES > LOAD_CYCLES) ? SETTLE_CYCLES : LOAD_CYCLES;
    localparam int unsigned PH_MAX = (SL_MAX > SHIFT_CYCLES) ? SL_MAX : SHIFT_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned CNT_W  = (GATE_WIDTH > PH_W) ? GATE_WIDTH : PH_W;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_GATE, S_LATCH, S_LOAD, S_SHIFT, S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            mask_q, mask_d;
    logic [GATE_WIDTH-1:0] gate_q, gate_d;
    logic [2:0]            pend_q, pend_d;
    logic [1:0]            sel_q, sel_d;

    logic                  ctr_reset_q, latch_q, send_q, frame_q, busy_q, done_q;
    logic [1:0]            csel_q;

    logic [1:0]            low_idx;
    logic [2:0]            low_clr;
    logic                  cnt_zero;
    logic [CNT_W-1:0]      gate_load;

    assign cnt_zero  = (cnt_q == '0);
    assign gate_load = (gate_q == '0) ? '0 : CNT_W'(gate_q - GATE_WIDTH'(1));

    // Lowest pending oscillator and the pending set with that bit removed.
    always_comb begin
        low_idx = 2'd0;
        low_clr = pend_q;
        if (pend_q[0]) begin
            low_idx = 2'd0;
            low_clr = pend_q & 3'b110;
        end else if (pend_q[1]) begin
            low_idx = 2'd1;
            low_clr = pend_q & 3'b100;
        end else if (pend_q[2]) begin
            low_idx = 2'd2;
            low_clr = 3'b000;
        end
    end

    // Next-state decision; counters count down and stick at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? '0 : cnt_q - CNT_W'(1);
        mask_d  = mask_q;
        gate_d  = gate_q;
        pend_d  = pend_q;
        sel_d   = sel_q;

        unique case (state_q)
            S_IDLE: begin
                if (ctl.start) begin
                    mask_d = ctl.ros_mask;
                    gate_d = ctl.gate_cycles;
                    if (ctl.ros_mask != 3'b000) begin
                        state_d = S_CLEAR;
                        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                        pend_d  = ctl.ros_mask;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                if (cnt_zero) begin
                    state_d = S_GATE;
                    cnt_d   = gate_load;
                end
            end
            S_GATE: begin
                if (cnt_zero) begin
                    state_d = S_LATCH;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            S_LATCH, S_SHIFT: begin
                // End of latch settle or of a frame: next oscillator or finish.
                if (cnt_zero) begin
                    if (pend_q != 3'b000) begin
                        state_d = S_LOAD;
                        cnt_d   = CNT_W'(LOAD_CYCLES - 1);
                        sel_d   = low_idx;
                        pend_d  = low_clr;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (cnt_zero) begin
                    state_d = S_SHIFT;
                    cnt_d   = CNT_W'(SHIFT_CYCLES - 1);
                end
            end
            S_DONE: begin
                if (ctl.continuous) begin
                    state_d = S_CLEAR;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    pend_d  = mask_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ctl.abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pend_d  = 3'b000;
        end
    end

    // State and registered outputs decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mask_q      <= 3'b000;
            gate_q      <= '0;
            pend_q      <= 3'b000;
            sel_q       <= 2'd0;
            ctr_reset_q <= 1'b0;
            latch_q     <= 1'b0;
            send_q      <= 1'b0;
            csel_q      <= 2'd0;
            frame_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            gate_q      <= gate_d;
            pend_q      <= pend_d;
            sel_q       <= sel_d;
            ctr_reset_q <= (state_d == S_CLEAR);
            latch_q     <= (state_d == S_LATCH) || (state_d == S_LOAD) || (state_d == S_SHIFT);
            send_q      <= (state_d == S_LOAD);
            csel_q      <= ((state_d == S_LOAD) || (state_d == S_SHIFT)) ? sel_d : 2'd0;
            frame_q     <= (state_d == S_LOAD) || (state_d == S_SHIFT);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign ctl.ctr_reset      = ctr_reset_q;
    assign ctl.latch_counter  = latch_q;
    assign ctl.send_counter   = send_q;
    assign ctl.counter_select = csel_q;
    assign ctl.frame_active   = frame_q;
    assign ctl.busy           = busy_q;
    assign ctl.done           = done_q;

endmodule

// File: tb/tb_tros_meas_sequencer.sv
// Self-checking bench: timeline model from the cycle formulas, table + random runs.
module tb_tros_meas_sequencer;

    localparam int GW  = 12;
    localparam int S   = 4;
    localparam int L   = 4;
    localparam int F   = 24;
    localparam int PER = L + F + 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tros_meas_sequencer_if #(.GATE_WIDTH(GW)) ifc ();

    tros_meas_sequencer #(
        .GATE_WIDTH   (GW),
        .SETTLE_CYCLES(S),
        .LOAD_CYCLES  (L),
        .FRAME_BITS   (F)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ctl  (ifc)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] mask;
        int         gate;
        int         extra;
        int         ab;
        int         exp_done;
    } vec_t;

    vec_t vecs[9];

    // {ctr_reset, latch, send, sel[1:0], frame_active, busy, done}
    function automatic logic [7:0] obs();
        return {ifc.ctr_reset, ifc.latch_counter, ifc.send_counter, ifc.counter_select,
                ifc.frame_active, ifc.busy, ifc.done};
    endfunction

    function automatic int popcnt(input logic [2:0] m);
        int n = 0;
        for (int i = 0; i < 3; i++) if (m[i]) n++;
        return n;
    endfunction

    function automatic int done_cycle(input logic [2:0] m, input int g);
        int gg = (g == 0) ? 1 : g;
        if (m == 3'b000) return 1;
        return 1 + 2*S + gg + popcnt(m)*PER;
    endfunction

    // Expected outputs at cycle t after a start sampled at cycle 0.
    function automatic logic [7:0] model(input int t, input logic [2:0] m, input int g, input int ab);
        logic [7:0] o;
        int gg, n, r, k, off, seen;
        o  = 8'h00;
        gg = (g == 0) ? 1 : g;
        n  = popcnt(m);
        if (ab > 0 && t > ab) return o;
        if (m == 3'b000) begin
            if (t == 1) o[1:0] = 2'b11;
        end else if (t <= S) begin
            o[7] = 1'b1; o[1] = 1'b1;
        end else if (t <= S + gg) begin
            o[1] = 1'b1;
        end else if (t <= 2*S + gg) begin
            o[6] = 1'b1; o[1] = 1'b1;
        end else begin
            r = t - (1 + 2*S + gg);
            k = r / PER;
            if (k < n) begin
                off  = r % PER;
                o[6] = 1'b1;
                o[5] = (off < L);
                o[2] = 1'b1;
                o[1] = 1'b1;
                seen = 0;
                for (int i = 0; i < 3; i++) begin
                    if (m[i]) begin
                        if (seen == k) o[4:3] = 2'(i);
                        seen++;
                    end
                end
            end else if (r == n*PER) begin
                o[1:0] = 2'b11;
            end
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start at the current cycle (cycle 0) and compare every following cycle.
    task automatic run_seq(input logic [2:0] m, input int g, input int extra,
                           input int ab, input int exp_done);
        int len, seen;
        ifc.ros_mask    = m;
        ifc.gate_cycles = GW'(g);
        ifc.abort       = 1'b0;
        ifc.start       = 1'b1;
        len  = (ab > 0) ? ab + 5 : done_cycle(m, g) + 3;
        seen = -1;
        for (int t = 1; t <= len; t++) begin
            @(posedge clk); #1;
            ifc.start = (t == extra);
            ifc.abort = (t == ab);
            if (t == 2) begin
                ifc.ros_mask    = ~m;
                ifc.gate_cycles = GW'(g + 7);
            end
            check($sformatf("m%0d_g%0d_cyc%0d", m, g, t), 32'(obs()), 32'(model(t, m, g, ab)));
            if (ifc.done && seen < 0) seen = t;
        end
        check($sformatf("done_cycle_m%0d_g%0d", m, g), 32'(seen), 32'(exp_done));
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, g, dc, ab;

        vecs[0] = '{3'd7, 100, 0, 0, 202};
        vecs[1] = '{3'd4, 0, 0, 0, 41};
        vecs[2] = '{3'd0, 55, 0, 0, 1};
        vecs[3] = '{3'd7, 100, 50, 0, 202};
        vecs[4] = '{3'd7, 100, 0, 120, -1};
        vecs[5] = '{3'd7, 100, 0, 0, 202};
        vecs[6] = '{3'd2, 1, 0, 0, 41};
        vecs[7] = '{3'd5, 3, 0, 0, 74};
        vecs[8] = '{3'd1, 4095, 0, 0, 4135};

        reset           = 1'b1;
        ifc.start       = 1'b0;
        ifc.abort       = 1'b0;
        ifc.continuous  = 1'b0;
        ifc.ros_mask    = 3'b000;
        ifc.gate_cycles = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(obs()), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            run_seq(vecs[i].mask, vecs[i].gate, vecs[i].extra, vecs[i].ab, vecs[i].exp_done);

        for (int i = 0; i < 25; i++) begin
            m  = int'($urandom_range(0, 7));
            g  = int'($urandom_range(0, 40));
            dc = done_cycle(3'(m), g);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, dc)) : 0;
            run_seq(3'(m), g, 0, ab, (ab > 0 && ab < dc) ? -1 : dc);
        end

        // Continuous mode: period 50, then reset in the middle of a gate window.
        ifc.continuous  = 1'b1;
        ifc.ros_mask    = 3'b001;
        ifc.gate_cycles = GW'(10);
        ifc.start       = 1'b1;
        for (int t = 1; t <= 158; t++) begin
            @(posedge clk); #1;
            ifc.start = 1'b0;
            check($sformatf("cont_done_cyc%0d", t), 32'(ifc.done), 32'((t % 50) == 0));
            check($sformatf("cont_clr_cyc%0d", t), 32'(ifc.ctr_reset),
                  32'(((t % 50) >= 1) && ((t % 50) <= 4)));
            check($sformatf("cont_busy_cyc%0d", t), 32'(ifc.busy), 32'h1);
            if (t == 158) reset = 1'b1;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_mid_gate", 32'(obs()), 32'h0);
        ifc.continuous = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            check("idle_after_reset", 32'(obs()), 32'h0);
        end
        run_seq(3'b000, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tros_meas_sequencer.md
# tros_meas_sequencer

Autonomous measurement sequencer for the temperature ring-oscillator array. It sits in the `clk` domain beside the serial readout shift register and replaces manual RP2040 bit-banging of `ctr_reset`, `latch_counter`, `send_counter` and `counter_select`. One `start` pulse runs a complete measurement: counter clear, a programmable gate window, latch, and Manchester readout of every oscillator selected in `ros_mask`. It can also repeat the measurement back-to-back.

## Interface
- `GATE_WIDTH`, default 16: width of the gate-window length in `clk` cycles.
- `SETTLE_CYCLES`, default 4: hold time for `ctr_reset`, and hold time of `latch_counter` before readout starts. Covers RO-domain synchronisation. Legal range ≥1.
- `LOAD_CYCLES`, default 4: `send_counter` high time. Must be ≥4 to pass the 3-flop `send_counter` synchroniser.
- `FRAME_BITS`, default 24: readout frame length (COUNTER_LENGTH+4: 4-bit `1010` preamble plus the counter).
- `clk` input 1: system clock, the same clock that drives the serial readout.
- `reset` input 1: synchronous, active-high.
- `start` input 1: single-cycle request. Sampled only in IDLE.
- `abort` input 1: synchronous abort, honoured in any state.
- `continuous` input 1: re-arm automatically after DONE.
- `gate_cycles` input GATE_WIDTH: gate-window length. The value 0 is treated as 1.
- `ros_mask` input 3: bit0 = nand4, bit1 = nand4_cap, bit2 = einv_sub.
- `ctr_reset` output 1: clears the frequency counters.
- `latch_counter` output 1: freezes the captured counts.
- `send_counter` output 1: load request to the readout shift register.
- `counter_select` output 2: oscillator index, driven during readout.
- `frame_active` output 1: high while a frame is being loaded or shifted.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at the end of a sequence.

## Operation
- `gate_cycles` and `ros_mask` are captured on the accepted `start`. Later input changes do not affect a running sequence.
- `continuous` is sampled in DONE.
- States and transitions:
  - IDLE: all outputs 0.
    - `start`=1 with mask≠0 → CLEAR.
    - `start`=1 with mask=0 → DONE. This gives a `done` pulse with no readout.
  - CLEAR: `ctr_reset`=1 for SETTLE_CYCLES cycles → GATE.
  - GATE: all control outputs 0. Lasts `max(gate_cycles,1)` cycles → LATCH.
  - LATCH: `latch_counter`=1 for SETTLE_CYCLES cycles → LOAD. `latch_counter` then stays 1 through LOAD, SHIFT and NEXT, so the counts remain frozen for the whole readout.
  - LOAD: `counter_select` is set to the lowest unserviced set bit of the captured mask. `send_counter`=1 and `frame_active`=1 for LOAD_CYCLES cycles → SHIFT.
  - SHIFT: `send_counter`=0, `frame_active`=1, `counter_select` held. Lasts FRAME_BITS+3 cycles; the extra 3 cover the synchroniser lag → NEXT.
  - NEXT: takes zero cycles. It is a combinational decision made on the last SHIFT cycle.
    - More mask bits pending → LOAD.
    - Otherwise → DONE.
  - DONE: `done`=1 for one cycle, all other outputs except `busy` are 0.
    - `continuous`=1 → CLEAR, with `busy` kept high.
    - Otherwise → IDLE.
- Oscillators are serviced in ascending index order. Unselected indices are skipped with no cycles spent on them.
- `counter_select`=3 is never driven.
- `start` is ignored while `busy`=1.
- `abort` has priority over `start`. From any state, the next state is IDLE, all outputs are 0, and no `done` pulse is produced.
- `reset` has priority over `abort`. It produces the same result as `abort`, clears the captured mask and gate length, and clears all internal counters.

## Timing
- Reset value of every output: 0.
- Let cycle 0 be the cycle in which `start` is sampled. S=SETTLE_CYCLES, G=max(gate_cycles,1), L=LOAD_CYCLES, F=FRAME_BITS, N=popcount(mask).
  - `ctr_reset` is high in cycles 1..S.
  - The gate window covers cycles S+1..S+G.
  - `latch_counter` rises at cycle S+G+1.
  - Frame k (k=0..N-1) starts at cycle 1+2S+G+k(L+F+3). Its `send_counter` high time is L cycles.
  - `done` pulses at cycle 1+2S+G+N(L+F+3). With mask=0, `done` pulses at cycle 1.
- Continuous mode: `ctr_reset` rises in the cycle after `done`.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Internal counters saturate and never wrap. The gate counter is GATE_WIDTH bits, so gate_cycles = 2^GATE_WIDTH−1 is legal and exact.

## Test plan
- Reset, then mask=3'b111, gate=100, default parameters → `ctr_reset` high in cycles 1–4; `latch_counter` rises at cycle 105; `counter_select` takes 0,1,2 with frames starting at cycles 109, 140, 171; `done` at cycle 202; `busy` low at cycle 203.
- mask=3'b100, gate=0 → gate lasts 1 cycle; a single frame with `counter_select`=2 starts at cycle 10; `done` at cycle 41.
- mask=3'b000 → `done` at cycle 1; `ctr_reset`, `latch_counter` and `send_counter` never assert.
- `start` pulsed again at cycle 50 of a running sequence → ignored; the timeline is identical to the first test.
- `abort` at cycle 120 (during the first frame) → all outputs 0 at cycle 121, no `done`; a new `start` at cycle 125 runs a normal sequence.
- `continuous`=1, mask=3'b001, gate=10 → `done` pulses every 1+8+10+31=50 cycles. `reset` asserted mid-GATE → all outputs 0 in the next cycle and the state is IDLE.
